fifo_rd_stream: RTL and testbench

- Read-side consumer of the asynchronous FIFO. Lives entirely in the read clock domain.
- Converts the FIFO's empty/r_en/d_out read interface into a valid/ready stream for downstream logic.
- Absorbs the FIFO's one-cycle read latency with a 3-entry prefetch buffer. This gives full throughput with no combinational path from m_ready to r_en.
- Also provides a delivered-beat counter and a synchronous flush.

---
 rtl/fifo_rd_stream.sv | 91 +++++++++
 tb/tb_fifo_rd_stream.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_rd_stream: turns the async FIFO read port into a valid/ready stream  |
// | through a 3-entry prefetch buffer, with beat counter and sync flush.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fifo_rd_stream #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             r_clk,
    input  logic             r_rst,
    input  logic             empty,
    input  logic [W-1:0]     fifo_dout,
    output logic             r_en,
    output logic [W-1:0]     m_data,
    output logic             m_valid,
    input  logic             m_ready,
    input  logic             flush,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] beat_cnt
);

    logic             inflight_q;
    logic [1:0]       occ_q, occ_d;
    logic [W-1:0]     buf_q [3];
    logic [W-1:0]     buf_d [3];
    logic [CNT_W-1:0] cnt_q;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_wr_idx;

    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = buf_q[0];
    assign occ      = occ_q;
    assign beat_cnt = cnt_q;

    assign w_push = inflight_q & ~flush;
    assign w_pop  = m_valid & m_ready & ~flush;

    // Reads are issued only when the word in flight is guaranteed a slot, so
    // m_ready never has to reach r_en. Held low while reset is asserted.
    assign r_en = r_rst & ~empty & ~flush
                & (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);

    always_comb begin
        buf_d    = buf_q;
        occ_d    = occ_q;
        w_wr_idx = occ_q - {1'b0, w_pop};
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            if (w_pop) begin
                buf_d[0] = buf_q[1];
                buf_d[1] = buf_q[2];
            end
            if (w_push) begin
                case (w_wr_idx)
                    2'd0:    buf_d[0] = fifo_dout;
                    2'd1:    buf_d[1] = fifo_dout;
                    2'd2:    buf_d[2] = fifo_dout;
                    default: ;
                endcase
            end
            occ_d = occ_q + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            buf_q[2]   <= '0;
            cnt_q      <= '0;
        end else begin
            inflight_q <= r_en & ~empty;
            occ_q      <= occ_d;
            buf_q      <= buf_d;
            if (w_pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    a_no_overflow: assert property (@(posedge r_clk) disable iff (!r_rst)
                                    !(w_push && occ_q == 2'd3));

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_rd_stream: directed and random stimulus against a queue model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fifo_rd_stream;

    logic        r_clk;
    logic        r_rst;
    logic        empty;
    logic [7:0]  fifo_dout;
    logic        r_en;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        flush;
    logic [1:0]  occ;
    logic [15:0] beat_cnt;

    logic        r_en4;
    logic [7:0]  m_data4;
    logic        m_valid4;
    logic [1:0]  occ4;
    logic [3:0]  beat_cnt4;

    fifo_rd_stream #(.W(8), .CNT_W(16)) dut (
        .r_clk(r_clk), .r_rst(r_rst), .empty(empty), .fifo_dout(fifo_dout),
        .r_en(r_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .flush(flush), .occ(occ), .beat_cnt(beat_cnt)
    );

    fifo_rd_stream #(.W(8), .CNT_W(4)) dut4 (
        .r_clk(r_clk), .r_rst(r_rst), .empty(empty), .fifo_dout(fifo_dout),
        .r_en(r_en4), .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
        .flush(flush), .occ(occ4), .beat_cnt(beat_cnt4)
    );

    always #5 r_clk = ~r_clk;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  fifo[$];     // words sitting in the upstream FIFO
    logic [7:0]  expq[$];     // words popped from the FIFO, not yet delivered
    logic        inflight_m;
    logic [15:0] mcnt;
    logic        gate_empty;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int exp_occ();
        return expq.size() - (inflight_m ? 1 : 0);
    endfunction

    task automatic settle();
        empty = gate_empty || (fifo.size() == 0);
        #1;
    endtask

    task automatic load(input int start, input int n);
        for (int i = 0; i < n; i++) fifo.push_back(8'(start + i));
    endtask

    // One clock: check outputs against the model, advance edge, update model.
    task automatic step();
        logic fire, pop;
        logic [7:0] w;
        settle();
        fire = (exp_occ() != 0) && m_ready && !flush;
        pop  = !empty && !flush && (expq.size() < 3);
        chk("occ", 32'(occ), 32'(exp_occ()));
        chk("m_valid", 32'(m_valid), 32'(exp_occ() != 0));
        chk("r_en", 32'(r_en), 32'(pop));
        chk("beat_cnt", 32'(beat_cnt), 32'(mcnt));
        chk("beat_cnt4", 32'(beat_cnt4), 32'(mcnt[3:0]));
        if (exp_occ() != 0) chk("m_data", 32'(m_data), 32'(expq[0]));
        @(posedge r_clk);
        #1;
        if (flush) begin
            expq.delete();
        end else if (fire) begin
            void'(expq.pop_front());
            mcnt++;
        end
        inflight_m = pop;
        if (pop) begin
            w = fifo.pop_front();
            fifo_dout = w;
            expq.push_back(w);
        end
    endtask

    // Asynchronous assertion: outputs must clear before any clock edge.
    task automatic apply_reset();
        r_rst = 1'b0;
        #1;
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("rst_r_en", 32'(r_en), 32'd0);
        fifo.delete();
        expq.delete();
        inflight_m = 1'b0;
        mcnt       = '0;
        fifo_dout  = '0;
        flush      = 1'b0;
        gate_empty = 1'b0;
        repeat (2) @(posedge r_clk);
        #1;
        r_rst = 1'b1;
    endtask

    initial begin
        r_clk = 0; r_rst = 0; empty = 1; fifo_dout = '0;
        m_ready = 0; flush = 0; gate_empty = 0; inflight_m = 0; mcnt = '0;
        #3;

        // Streaming 0..19 at full rate
        apply_reset();
        load(0, 20);
        m_ready = 1;
        settle();
        chk("p1_first_ren", 32'(r_en), 32'd1);
        repeat (26) step();
        settle();
        chk("p1_cnt", 32'(beat_cnt), 32'd20);
        chk("p1_occ", 32'(occ), 32'd0);
        chk("p1_ren_empty", 32'(r_en), 32'd0);

        // Backpressure stall
        apply_reset();
        load(0, 10);
        m_ready = 0;
        repeat (8) step();
        settle();
        chk("p2_occ_full", 32'(occ), 32'd3);
        chk("p2_ren_off", 32'(r_en), 32'd0);
        chk("p2_hold_data", 32'(m_data), 32'd0);
        m_ready = 1;
        repeat (14) step();
        settle();
        chk("p2_cnt", 32'(beat_cnt), 32'd10);

        // Toggling ready
        apply_reset();
        load(20, 15);
        for (int i = 0; i < 40; i++) begin
            m_ready = (i % 2 == 0);
            step();
        end
        settle();
        chk("p3_cnt", 32'(beat_cnt), 32'd15);

        // Empty toggling
        apply_reset();
        load(40, 10);
        m_ready = 1;
        for (int i = 0; i < 40; i++) begin
            gate_empty = (i % 2 == 1);
            step();
        end
        gate_empty = 0;
        settle();
        chk("p4_cnt", 32'(beat_cnt), 32'd10);

        // Flush with occ=2 and one word in flight
        apply_reset();
        load(60, 10);
        m_ready = 0;
        repeat (3) step();
        settle();
        chk("p5_occ_pre", 32'(occ), 32'd2);
        chk("p5_ren_pre", 32'(r_en), 32'd0);
        flush = 1;
        step();
        flush = 0;
        settle();
        chk("p5_occ_post", 32'(occ), 32'd0);
        chk("p5_valid_post", 32'(m_valid), 32'd0);
        chk("p5_cnt_post", 32'(beat_cnt), 32'd0);
        m_ready = 1;
        for (int i = 0; i < 5; i++) begin
            settle();
            if (m_valid) break;
            step();
        end
        settle();
        chk("p5_next_word", 32'(m_data), 32'd63);
        repeat (12) step();
        settle();
        chk("p5_cnt", 32'(beat_cnt), 32'd7);

        // Random traffic with occasional flush
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            if (fifo.size() < 3 && $urandom_range(0, 1) == 1) fifo.push_back(8'($urandom));
            m_ready    = ($urandom_range(0, 1) == 1);
            gate_empty = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 19) == 0);
            step();
        end
        flush = 0; gate_empty = 0; m_ready = 1;
        repeat (20) step();
        settle();
        chk("p6_drained", 32'(occ), 32'd0);

        // Reset mid-stream with a full buffer, then fresh traffic and wrap
        apply_reset();
        load(0, 12);
        m_ready = 1;
        repeat (5) step();
        m_ready = 0;
        repeat (6) step();
        settle();
        chk("p7_occ_full", 32'(occ), 32'd3);
        apply_reset();
        load(100, 5);
        m_ready = 1;
        repeat (12) step();
        settle();
        chk("p7_cnt5", 32'(beat_cnt), 32'd5);
        chk("p7_cnt4_5", 32'(beat_cnt4), 32'd5);
        load(105, 12);
        repeat (20) step();
        settle();
        chk("p7_cnt17", 32'(beat_cnt), 32'd17);
        chk("p7_wrap", 32'(beat_cnt4), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
